filter2d_window_gen: RTL and testbench
======================================

Name: filter2d_window_gen

Overview:
Streaming window generator that sits directly upstream of the 2-D filter core. It accepts a raster-order pixel stream, one pixel per cycle at most, and buffers WIN_SIZE-1 image lines internally. For every pixel position whose full WIN_SIZE x WIN_SIZE neighbourhood lies inside the image, it emits that neighbourhood as a packed window with a valid strobe ("valid" convolution, no padding). There is no backpressure, because the downstream core always accepts.

Parameters:
DIN_WIDTH, 8, pixel width in bits.
WIN_SIZE, 3, window side length; legal values are 2..7.
IMG_WIDTH, 640, pixels per line; must be >= WIN_SIZE.
IMG_HEIGHT, 480, lines per frame; must be >= WIN_SIZE.

Ports:
clk  input  1  clock; all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
pix_vld  input  1  pix is valid this cycle; the pixel is accepted when high.
pix_sof  input  1  start of frame; qualified by pix_vld and marks the pixel at (row 0, col 0).
pix  input  DIN_WIDTH  pixel data.
win_vld  output  1  window valid; single-cycle strobe per window.
window  output  [WIN_SIZE-1:0][WIN_SIZE-1:0][DIN_WIDTH-1:0]  window[i][j]: i is the row (0 = oldest line), j is the column (0 = leftmost).
win_eof  output  1  high together with win_vld on the last window of a frame.

Behaviour:
- Reset: clk and reset_n as already decided (reset_n asynchronous, active-low; clock clk). On reset, win_vld=0, win_eof=0, window='0, col=0, row=0. Line-buffer RAM contents are don't-care and are not reset.
- Position tracking:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1; both advance only on accepted pixels.
  - col wraps to 0 after IMG_WIDTH-1 and increments row.
  - row wraps to 0 after (IMG_HEIGHT-1, IMG_WIDTH-1), so back-to-back frames work without pix_sof.
- pix_sof: an accepted pixel with pix_sof=1 is treated as (0,0) whatever the counter state. Counters restart so that the next accepted pixel is (0,1). A mid-frame pix_sof abandons the current frame, and no window from the abandoned frame is emitted afterwards.
- Line buffers:
  - WIN_SIZE-1 buffers, each IMG_WIDTH x DIN_WIDTH, indexed by col. They may be single-port read-before-write or a register chain.
  - On an accepted pixel at column c: buffer 0 is written with pix, and buffer k (k >= 1) is written with the old content of buffer k-1 at c.
  - The read values at c form the new column: {buf[WIN_SIZE-2](c) ... buf[0](c), pix}, oldest line first.
- Window shift register: on an accepted pixel, columns shift toward j=0 and the new column enters at j=WIN_SIZE-1. Result: window[WIN_SIZE-1][WIN_SIZE-1] = the current pixel (r,c), and window[i][j] = pixel (r-WIN_SIZE+1+i, c-WIN_SIZE+1+j).
- Output validity:
  - win_vld is registered and asserted exactly 1 cycle after an accepted pixel with row >= WIN_SIZE-1 and col >= WIN_SIZE-1. It is 0 in all other cycles.
  - win_eof = win_vld for the pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Latency is fixed at 1 cycle from pixel acceptance to window output.
- Columns spanning a line boundary are suppressed by the col condition, not by clearing the shift register.
- Idle cycles (pix_vld=0): all state holds, win_vld=0, and window holds its last value.
- Windows per frame: (IMG_HEIGHT-WIN_SIZE+1)*(IMG_WIDTH-WIN_SIZE+1).
- Reset mid-frame: the next accepted pixel is (0,0) and no windows are emitted until row WIN_SIZE-1 of the new frame. Stale RAM contents never reach a valid window.
- pix_sof while pix_vld=0 is ignored.

Test Plan:
1. IMG_WIDTH=8, IMG_HEIGHT=6, WIN_SIZE=3, pix = row*16+col, continuous pix_vld, pix_sof on the first pixel -> the first win_vld occurs 1 cycle after pixel 0x22 with window[0][0]=0x00, [0][2]=0x02, [2][0]=0x20, [2][2]=0x22. Exactly 24 windows per frame; win_eof only on the window whose [2][2]=0x57.
2. Same image with pix_vld randomly deasserted about 50% of the time -> a window sequence identical to scenario 1. win_vld is never high in a cycle that follows an idle cycle, and window is stable during gaps.
3. Two frames back to back without pix_sof on the second -> 48 windows; the first window of frame 2 equals the first window of frame 1.
4. pix_sof asserted at pixel (3,4) of frame 1, then a full frame -> no windows from the abandoned frame after the sof. The next window is frame 2's (2,2) window with correct contents.
5. reset_n pulsed low asynchronously mid-row 4 -> win_vld, win_eof and window are 0 immediately. After release, a full frame yields 24 correct windows.
6. WIN_SIZE=5, IMG_WIDTH=5, IMG_HEIGHT=5 -> exactly one window, 1 cycle after pixel (4,4), equal to the whole image, with win_vld=win_eof=1.

Source files
------------

// File: rtl/filter2d_window_gen.sv
// Raster-stream window generator for the 2-D filter core.
// Emits each fully-inside WIN_SIZE x WIN_SIZE neighbourhood one cycle after its last pixel.
module filter2d_window_gen #(
  parameter int DIN_WIDTH  = 8,
  parameter int WIN_SIZE   = 3,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pix_vld,
  input  logic pix_sof,
  input  logic [DIN_WIDTH-1:0] pix,
  output logic win_vld,
  output logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DIN_WIDTH-1:0] window,
  output logic win_eof
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int NB = WIN_SIZE - 1;

  typedef logic [DIN_WIDTH-1:0] pix_t;

  logic [CW-1:0] col;
  logic [CW-1:0] cur_col;
  logic [CW-1:0] nxt_col;
  logic [RW-1:0] row;
  logic [RW-1:0] cur_row;
  logic [RW-1:0] nxt_row;
  logic          last_col;
  logic          last_row;
  logic          in_win;

  pix_t lbuf [NB][IMG_WIDTH];
  pix_t rd   [NB];

  // sof forces the current pixel to (0,0) regardless of counter state
  always_comb begin
    cur_col  = pix_sof ? '0 : col;
    cur_row  = pix_sof ? '0 : row;
    last_col = (cur_col == CW'(IMG_WIDTH - 1));
    last_row = (cur_row == RW'(IMG_HEIGHT - 1));
    nxt_col  = last_col ? '0 : cur_col + CW'(1);
    if (!last_col)
      nxt_row = cur_row;
    else if (last_row)
      nxt_row = '0;
    else
      nxt_row = cur_row + RW'(1);
    in_win = (cur_row >= RW'(WIN_SIZE - 1)) &&
             (cur_col >= CW'(WIN_SIZE - 1));
    for (int k = 0; k < NB; k++)
      rd[k] = lbuf[k][cur_col];
  end

  // line buffers are not reset; stale lines are masked by the row check
  always_ff @(posedge clk) begin
    if (pix_vld) begin
      lbuf[0][cur_col] <= pix;
      for (int k = 1; k < NB; k++)
        lbuf[k][cur_col] <= rd[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col     <= '0;
      row     <= '0;
      win_vld <= 1'b0;
      win_eof <= 1'b0;
      window  <= '0;
    end else begin
      win_vld <= 1'b0;
      win_eof <= 1'b0;
      if (pix_vld) begin
        col     <= nxt_col;
        row     <= nxt_row;
        win_vld <= in_win;
        win_eof <= in_win && last_row && last_col;
        for (int j = 0; j < WIN_SIZE - 1; j++)
          for (int i = 0; i < WIN_SIZE; i++)
            window[i][j] <= window[i][j+1];
        for (int i = 0; i < NB; i++)
          window[i][WIN_SIZE-1] <= rd[NB-1-i];
        window[WIN_SIZE-1][WIN_SIZE-1] <= pix;
      end
    end
  end

endmodule

// File: tb/tb_filter2d_window_gen.sv
// Randomized bench for filter2d_window_gen: image-array reference model,
// an 8x6/3x3 instance plus a 5x5/5x5 instance for the single-window case.
module tb_filter2d_window_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WS = 3;
  localparam int DW = 8;

  typedef logic [WS-1:0][WS-1:0][DW-1:0] win_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pix_vld;
  logic          pix_sof;
  logic [DW-1:0] pix;
  logic          win_vld;
  logic          win_eof;
  win_t          window;

  logic          p5_vld;
  logic          p5_sof;
  logic [7:0]    p5;
  logic          w5_vld;
  logic          w5_eof;
  logic [4:0][4:0][7:0] w5;

  int   n_chk = 0;
  int   n_fail = 0;

  int   m_r;
  int   m_c;
  logic exp_vld;
  logic exp_eof;
  logic known;
  win_t exp_win;
  logic [DW-1:0] img [H][W];

  win_t win_q[$];
  win_t eof_win;
  int   n_eof;

  filter2d_window_gen #(
    .DIN_WIDTH(DW), .WIN_SIZE(WS),
    .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pix_vld(pix_vld), .pix_sof(pix_sof),
    .pix(pix), .win_vld(win_vld),
    .window(window), .win_eof(win_eof)
  );

  filter2d_window_gen #(
    .DIN_WIDTH(8), .WIN_SIZE(5),
    .IMG_WIDTH(5), .IMG_HEIGHT(5)
  ) dut5 (
    .clk(clk), .reset_n(reset_n),
    .pix_vld(p5_vld), .pix_sof(p5_sof),
    .pix(p5), .win_vld(w5_vld),
    .window(w5), .win_eof(w5_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [71:0] act,
                     logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_r     = 0;
    m_c     = 0;
    exp_vld = 1'b0;
    exp_eof = 1'b0;
    exp_win = '0;
    known   = 1'b1;
  endtask

  // Advance one clock: predict, then sample 1 time unit after the edge.
  task automatic tick();
    int r;
    int c;
    int lin;
    if (pix_vld) begin
      r = pix_sof ? 0 : m_r;
      c = pix_sof ? 0 : m_c;
      img[r][c] = pix;
      if (r >= WS - 1 && c >= WS - 1) begin
        for (int i = 0; i < WS; i++)
          for (int j = 0; j < WS; j++)
            exp_win[i][j] = img[r-WS+1+i][c-WS+1+j];
        exp_vld = 1'b1;
        exp_eof = (r == H - 1) && (c == W - 1);
        known   = 1'b1;
      end else begin
        exp_vld = 1'b0;
        exp_eof = 1'b0;
        known   = 1'b0;
      end
      lin = (r * W + c + 1) % (W * H);
      m_r = lin / W;
      m_c = lin % W;
    end else begin
      exp_vld = 1'b0;
      exp_eof = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("win_vld", 72'(win_vld), 72'(exp_vld));
    chk("win_eof", 72'(win_eof), 72'(exp_eof));
    if (known)
      chk("window", window, exp_win);
    if (win_vld === 1'b1)
      win_q.push_back(window);
    if (win_eof === 1'b1) begin
      eof_win = window;
      n_eof++;
    end
  endtask

  task automatic idle();
    pix_vld = 1'b0;
    pix_sof = 1'($urandom_range(1));
    pix     = 8'($urandom);
    tick();
  endtask

  task automatic send(int base, bit sof, int gap, int npix);
    int r;
    int c;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / W;
      c = idx % W;
      while (int'($urandom_range(99)) < gap)
        idle();
      pix_vld = 1'b1;
      pix_sof = sof && (idx == 0);
      pix     = 8'(base + r * 16 + c);
      tick();
    end
    pix_vld = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic clear_log();
    win_q.delete();
    n_eof   = 0;
    eof_win = '0;
  endtask

  initial begin
    win_t w;
    int   bad;
    reset_n = 1'b0;
    pix_vld = 1'b0;
    pix_sof = 1'b0;
    pix     = '0;
    p5_vld  = 1'b0;
    p5_sof  = 1'b0;
    p5      = '0;
    model_reset();
    clear_log();
    #12;
    chk("rst_vld", 72'(win_vld), 72'(0));
    chk("rst_eof", 72'(win_eof), 72'(0));
    chk("rst_win", window, 72'(0));
    chk("rst_w5vld", 72'(w5_vld), 72'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: continuous frame
    send(0, 1'b1, 0, W * H);
    idle();
    w = win_q[0];
    chk("t1_count", 72'(win_q.size()), 72'(24));
    chk("t1_w00", 72'(w[0][0]), 72'(8'h00));
    chk("t1_w02", 72'(w[0][2]), 72'(8'h02));
    chk("t1_w20", 72'(w[2][0]), 72'(8'h20));
    chk("t1_w22", 72'(w[2][2]), 72'(8'h22));
    chk("t1_neof", 72'(n_eof), 72'(1));
    chk("t1_eof22", 72'(eof_win[2][2]), 72'(8'h57));
    clear_log();

    // 2: same image with random gaps
    send(0, 1'b1, 50, W * H);
    idle();
    w = win_q[0];
    chk("t2_count", 72'(win_q.size()), 72'(24));
    chk("t2_w22", 72'(w[2][2]), 72'(8'h22));
    chk("t2_neof", 72'(n_eof), 72'(1));
    clear_log();

    // 3: back-to-back frames, no sof on the second
    send(0, 1'b1, 0, W * H);
    send(0, 1'b0, 0, W * H);
    idle();
    w = win_q[24];
    chk("t3_count", 72'(win_q.size()), 72'(48));
    chk("t3_f2w00", 72'(w[0][0]), 72'(8'h00));
    chk("t3_f2w22", 72'(w[2][2]), 72'(8'h22));
    chk("t3_neof", 72'(n_eof), 72'(2));
    clear_log();

    // 4: sof lands on pixel (3,4) of the first frame
    send(0, 1'b1, 25, 3 * W + 4);
    clear_log();
    send(8'h80, 1'b1, 25, W * H);
    idle();
    w = win_q[0];
    bad = 0;
    foreach (win_q[k])
      if (win_q[k][0][0] < 8'h80)
        bad++;
    chk("t4_count", 72'(win_q.size()), 72'(24));
    chk("t4_stale", 72'(bad), 72'(0));
    chk("t4_w00", 72'(w[0][0]), 72'(8'h80));
    chk("t4_w22", 72'(w[2][2]), 72'(8'hA2));
    clear_log();

    // 5: asynchronous reset mid row 4
    send(0, 1'b1, 0, 4 * W + 4);
    reset_n = 1'b0;
    #1;
    chk("t5_vld", 72'(win_vld), 72'(0));
    chk("t5_eof", 72'(win_eof), 72'(0));
    chk("t5_win", window, 72'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_log();
    send(8'h40, 1'b0, 20, W * H);
    idle();
    w = win_q[0];
    chk("t5_count", 72'(win_q.size()), 72'(24));
    chk("t5_w00", 72'(w[0][0]), 72'(8'h40));
    chk("t5_eof22", 72'(eof_win[2][2]), 72'(8'h97));
    clear_log();

    // 6: 5x5 image with a 5x5 window
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        p5_vld = 1'b1;
        p5_sof = (r == 0) && (c == 0);
        p5     = 8'(r * 16 + c);
        tick();
        chk("t6_vld", 72'(w5_vld),
            72'((r == 4) && (c == 4)));
        chk("t6_eof", 72'(w5_eof),
            72'((r == 4) && (c == 4)));
      end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        chk("t6_win", 72'(w5[i][j]), 72'(i * 16 + j));
    p5_vld = 1'b0;
    p5_sof = 1'b0;
    tick();
    chk("t6_after", 72'(w5_vld), 72'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
